// File: rtl/multicycle_main_fsm.sv
// Main control FSM for a multicycle ARM-style datapath.
// Sequences fetch, decode, memory, data-processing and branch(-with-link)
// instructions, with optional memory wait-state handshaking.
module multicycle_main_fsm #(
  parameter int MEM_WAIT_EN = 1,
  parameter int BL_EN       = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       AdrSrc,
  output logic       LinkW,
  output logic       Illegal,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXER   = 4'd6,
    EXEI   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    LINK   = 4'd10
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   ready;
  logic   unused_funct;

  // With the handshake disabled, memory is assumed to answer in one cycle.
  assign ready = (MEM_WAIT_EN != 0) ? MemReady : 1'b1;

  // Funct[3:1] carry no control meaning for this FSM.
  assign unused_funct = ^Funct[3:1];

  // State register; reset drops straight back to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; Op/Funct only matter in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = ready ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXEI : EXER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = ((BL_EN != 0) && Funct[4]) ? LINK : BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = ready ? MEMWB : MEMRD;
      MEMWR:  state_d = ready ? FETCH : MEMWR;
      MEMWB:  state_d = FETCH;
      EXER:   state_d = ALUWB;
      EXEI:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      LINK:   state_d = BRANCH;
      default: state_d = FETCH;
    endcase
  end

  // Moore output decode; FETCH strobes and DECODE Illegal are the only gated ones.
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    AdrSrc    = 1'b0;
    LinkW     = 1'b0;
    Illegal   = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = ready;
        NextPC    = ready;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        Illegal   = (Op == 2'b11);
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXER:   ALUOp = 1'b1;
      EXEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB:  RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      LINK: begin
        ResultSrc = 2'b11;
        RegW      = 1'b1;
        LinkW     = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate and register-source selects follow the instruction class directly.
  assign ImmSrc    = Op;
  assign RegSrc[0] = (Op == 2'b10);
  assign RegSrc[1] = (Op == 2'b01) && !Funct[0];
  assign State     = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: default instance plus one with
// the memory handshake and branch-with-link both disabled, driven in lockstep.
module tb_multicycle_main_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] op;
  logic [5:0] funct;
  logic       memReady;

  logic [1:0] irWrite, nextPc, regW, memW, branch, aluOp, adrSrc, linkW, illegal, aluSrcA;
  logic [1:0] aluSrcB [2];
  logic [1:0] resultSrc [2];
  logic [1:0] immSrc [2];
  logic [1:0] regSrc [2];
  logic [3:0] stateObs [2];

  int passed = 0;
  int total  = 0;

  // Per-instance plan of upcoming states; an empty plan means FETCH.
  int plan [2][8];
  int plen [2];

  multicycle_main_fsm dut0 (
    .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .MemReady(memReady),
    .IRWrite(irWrite[0]), .NextPC(nextPc[0]), .RegW(regW[0]), .MemW(memW[0]),
    .Branch(branch[0]), .ALUOp(aluOp[0]), .AdrSrc(adrSrc[0]), .LinkW(linkW[0]),
    .Illegal(illegal[0]), .ALUSrcA(aluSrcA[0]), .ALUSrcB(aluSrcB[0]),
    .ResultSrc(resultSrc[0]), .ImmSrc(immSrc[0]), .RegSrc(regSrc[0]), .State(stateObs[0])
  );

  multicycle_main_fsm #(.MEM_WAIT_EN(0), .BL_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .MemReady(memReady),
    .IRWrite(irWrite[1]), .NextPC(nextPc[1]), .RegW(regW[1]), .MemW(memW[1]),
    .Branch(branch[1]), .ALUOp(aluOp[1]), .AdrSrc(adrSrc[1]), .LinkW(linkW[1]),
    .Illegal(illegal[1]), .ALUSrcA(aluSrcA[1]), .ALUSrcB(aluSrcB[1]),
    .ResultSrc(resultSrc[1]), .ImmSrc(immSrc[1]), .RegSrc(regSrc[1]), .State(stateObs[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int curState(input int k);
    return (plen[k] > 0) ? plan[k][0] : 0;
  endfunction

  task automatic pushState(input int k, input int s);
    plan[k][plen[k]] = s;
    plen[k]++;
  endtask

  task automatic popState(input int k);
    if (plen[k] > 0) begin
      for (int i = 0; i < plen[k] - 1; i++) plan[k][i] = plan[k][i+1];
      plen[k]--;
    end
  endtask

  // Advance one clock: wait states repeat while memory is busy; DECODE
  // schedules the whole instruction body, MEMADR picks load or store.
  task automatic modelStep(input int k, input bit rdy, input bit blEn);
    int cur;
    cur = curState(k);
    if ((cur == 0 || cur == 3 || cur == 5) && !rdy) return;
    popState(k);
    case (cur)
      0: pushState(k, 1);
      1: begin
        case (op)
          2'b00: begin pushState(k, funct[5] ? 7 : 6); pushState(k, 8); end
          2'b01: pushState(k, 2);
          2'b10: begin
            if (blEn && funct[4]) pushState(k, 10);
            pushState(k, 9);
          end
          default: ;
        endcase
      end
      2: begin
        if (funct[0]) begin pushState(k, 3); pushState(k, 4); end
        else pushState(k, 5);
      end
      default: ;
    endcase
  endtask

  // Output table written straight from the control-signal list per state.
  function automatic logic [17:0] expOutputs(input int s, input bit rdy,
                                             input logic [1:0] o, input logic [5:0] f);
    logic irw, npc, rw, mw, br, aop, adr, lw, ill, sa;
    logic [1:0] sb, rs;
    {irw, npc, rw, mw, br, aop, adr, lw, ill, sa} = '0;
    sb = 2'b00;
    rs = 2'b00;
    case (s)
      0:  begin sa = 1; sb = 2'b10; rs = 2'b10; irw = rdy; npc = rdy; end
      1:  begin sa = 1; sb = 2'b10; rs = 2'b10; ill = (o == 2'b11); end
      2:  sb = 2'b01;
      3:  adr = 1;
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  aop = 1;
      7:  begin sb = 2'b01; aop = 1; end
      8:  rw = 1;
      9:  begin sb = 2'b01; rs = 2'b10; br = 1; end
      10: begin rs = 2'b11; rw = 1; lw = 1; end
      default: ;
    endcase
    return {irw, npc, rw, mw, br, aop, adr, lw, ill, sa, sb, rs, o,
            (o == 2'b01) && !f[0], (o == 2'b10)};
  endfunction

  function automatic logic [17:0] obsOutputs(input int k);
    return {irWrite[k], nextPc[k], regW[k], memW[k], branch[k], aluOp[k], adrSrc[k],
            linkW[k], illegal[k], aluSrcA[k], aluSrcB[k], resultSrc[k], immSrc[k], regSrc[k]};
  endfunction

  task automatic compareAll();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("state_dut%0d", k), 32'(stateObs[k]), 32'(curState(k)));
      checkOutput($sformatf("outputs_dut%0d_st%0d", k, curState(k)), 32'(obsOutputs(k)),
                  32'(expOutputs(curState(k), (k == 0) ? memReady : 1'b1, op, funct)));
    end
  endtask

  // One clock: check mid-cycle, predict the next edge, land at posedge+1.
  task automatic cycle();
    @(negedge clk);
    compareAll();
    modelStep(0, memReady, 1'b1);
    modelStep(1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    op       = 2'($urandom);
    funct    = 6'($urandom);
    memReady = ($urandom_range(0, 3) != 0);
  endtask

  // Asynchronous reset mid-cycle, held across one rising edge.
  task automatic doReset();
    #2 rst_n = 1'b0;
    plen[0] = 0;
    plen[1] = 0;
    #1;
    compareAll();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drive one instruction on dut0 with chosen stalls in FETCH and memory states.
  task automatic runInstr(input logic [1:0] o, input logic [5:0] f,
                          input int fetchStall, input int memStall);
    bit started = 0;
    int cur;
    int guard;
    op = o;
    funct = f;
    for (guard = 0; guard < 40; guard++) begin
      cur = curState(0);
      if (cur == 0 && started) break;
      if (cur == 0 && fetchStall > 0) begin memReady = 0; fetchStall--; end
      else if ((cur == 3 || cur == 5) && memStall > 0) begin memReady = 0; memStall--; end
      else memReady = 1;
      if (cur != 0) started = 1;
      cycle();
    end
    if (guard >= 40) checkOutput("runInstr_budget", 32'(guard), 32'd0);
  endtask

  initial begin
    int seen;
    plen[0] = 0;
    plen[1] = 0;
    rst_n = 1'b0;
    op = 2'b00;
    funct = 6'b0;
    memReady = 1'b1;
    #3;
    compareAll();
    @(posedge clk);
    #1 rst_n = 1'b1;

    runInstr(2'b00, 6'b100000, 0, 0);
    runInstr(2'b01, 6'b000001, 0, 2);
    runInstr(2'b01, 6'b000000, 1, 0);
    runInstr(2'b10, 6'b010000, 0, 0);
    runInstr(2'b10, 6'b000000, 0, 0);
    runInstr(2'b11, 6'b000000, 0, 0);
    runInstr(2'b00, 6'b000000, 0, 0);

    // Park dut0 in a stalled store, then reset while MemW is asserted.
    op = 2'b01;
    funct = 6'b000000;
    seen = 0;
    for (int g = 0; g < 20; g++) begin
      if (curState(0) == 5) begin
        if (seen >= 2) break;
        seen++;
        memReady = 0;
      end else memReady = 1;
      cycle();
    end
    checkOutput("memwr_parked_dut0", 32'(stateObs[0]), 32'd5);
    doReset();
    checkOutput("memw_after_reset", 32'(memW[0]), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      if ($urandom_range(0, 49) == 0) doReset();
      cycle();
    end

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_main_fsm.md
MULTICYCLE_MAIN_FSM -- requirements
Module: multicycle_main_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1, meaning memory handshake enabled (0: MemReady ignored, treated as 1).
REQ-002 SHALL have parameter BL_EN, default 1, meaning branch-with-link support enabled.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 Op  in  2  instruction class (00 DP, 01 mem, 10 branch, 11 illegal).
REQ-007 Funct  in  6  instr[25:20]; Funct[5]=I, Funct[4]=L (branch), Funct[0]=S/L (mem).
REQ-008 MemReady  in  1  memory access complete this cycle.
REQ-009 IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, LinkW, Illegal  out  1 each  control strobes.
REQ-010 ALUSrcA  out  1; ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2 each  mux selects.
REQ-011 State  out  4  current state encoding, debug.

Function
REQ-012 States and encodings SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXER=6, EXEI=7, ALUWB=8, BRANCH=9, LINK=10; 11-15 unreachable, recover to FETCH next cycle.
REQ-013 Ready SHALL denote MemReady when MEM_WAIT_EN=1, constant 1 otherwise.
REQ-014 FETCH SHALL hold while !Ready, else go DECODE.
REQ-015 DECODE: Op=01 -> MEMADR; Op=00, Funct[5]=0 -> EXER; Op=00, Funct[5]=1 -> EXEI; Op=10 with BL_EN=1 and Funct[4]=1 -> LINK; Op=10 otherwise -> BRANCH; Op=11 -> FETCH.
REQ-016 MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
REQ-017 MEMRD SHALL hold while !Ready, else MEMWB; MEMWR SHALL hold while !Ready, else FETCH.
REQ-018 MEMWB, ALUWB, BRANCH -> FETCH; EXER, EXEI -> ALUWB; LINK -> BRANCH.
REQ-019 Outputs SHALL be Moore decode of State except gating noted; all unlisted strobes 0, unlisted selects 00.
REQ-020 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, IRWrite=NextPC=Ready.
REQ-021 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; Illegal=1 when Op=11.
REQ-022 MEMADR: ALUSrcA=0, ALUSrcB=01. MEMRD: AdrSrc=1. MEMWB: ResultSrc=01, RegW=1.
REQ-023 MEMWR: AdrSrc=1, MemW=1 held every cycle until exit.
REQ-024 EXER: ALUSrcA=0, ALUSrcB=00, ALUOp=1. EXEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. ALUWB: ResultSrc=00, RegW=1.
REQ-025 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-026 LINK: ResultSrc=11 (PC, already PC+4), RegW=1, LinkW=1 (forces Rd=R14).
REQ-027 ImmSrc SHALL equal Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01 and Funct[0]=0); state-independent combinational.
REQ-028 Zero-wait latency SHALL be: B 3 cycles, BL 4, DP 4, STR 4, LDR 5, illegal 2.
REQ-029 Each cycle of !Ready in FETCH, MEMRD or MEMWR SHALL add exactly one cycle; no other state observes MemReady.
REQ-030 Op/Funct SHALL be sampled only in DECODE and MEMADR; changes elsewhere have no effect.

Reset
REQ-031 rst_n low SHALL force State=FETCH asynchronously; outputs immediately show FETCH decode.
REQ-032 Reset asserted mid-instruction (any state, including wait) SHALL abandon it; no RegW/MemW after rst_n assertion.
REQ-033 First transition after rst_n deassertion SHALL occur on the first rising clk edge with rst_n high.

Verification
REQ-034 Reset, MemReady=1, Op=00, Funct=100000 -> States 0,1,7,8,0; RegW=1 only in cycle 4; ALUOp=1 in cycle 3.
REQ-035 Op=01, Funct[0]=1, MemReady low 2 cycles in MEMRD -> States 0,1,2,3,3,3,4,0; RegW=1 only in MEMWB.
REQ-036 Op=01, Funct[0]=0, MemReady=0 in FETCH 1 cycle -> States 0,0,1,2,5,0; IRWrite=0 then 1; MemW=1 one cycle; RegSrc=10.
REQ-037 Op=10, Funct[4]=1: BL_EN=1 -> States 0,1,10,9,0 with LinkW=RegW=1 in LINK; BL_EN=0 -> 0,1,9,0.
REQ-038 Op=11 -> States 0,1,0; Illegal=1 exactly one cycle; rst_n pulsed low during MEMWR -> State=0 same cycle, MemW=0.
